// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
//   Parallel-in / serial-out converter with a valid/ready input handshake.
//   A one-word holding buffer (hold_r) lets back-to-back words stream with no
//   gap bits. shift_en is the bit-rate tick; LSB_FIRST selects the shift order.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous reset, active high
//   din_data      parallel input word (WIDTH bits)
//   din_valid     din_data is valid
//   din_ready     block can accept a word this cycle (decoded from hold_full_r)
//   shift_en      bit-rate tick; tie high for one bit per clock
//   serial_out    serial data
//   serial_valid  serial_out carries a data bit
//   serial_first  serial_out is the first bit of a word
//   serial_last   serial_out is the final bit of a word
//   busy          a word is shifting or waiting in the holding buffer
// -----------------------------------------------------------------------------
module piso_stream #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_data,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             serial_first,
    output logic             serial_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   hold_r, hold_nxt_s;
    logic               hold_full_r, hold_full_nxt_s;
    logic [WIDTH-1:0]   sreg_r, sreg_nxt_s;
    logic [CW-1:0]      cnt_r, cnt_nxt_s;
    logic               out_r, out_nxt_s;
    logic               valid_r, valid_nxt_s;
    logic               first_r, first_nxt_s;
    logic               last_r, last_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               accept_s;
    logic               load_s;

    // Bit that leaves the word first for the configured shift order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (LSB_FIRST) begin
            return w[0];
        end else begin
            return w[WIDTH-1];
        end
    endfunction

    // Word with the first-out bit removed, remaining bits moved toward the exit.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (LSB_FIRST) begin
            return {1'b0, w[WIDTH-1:1]};
        end else begin
            return {w[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Ready depends only on the holding flag, never on din_valid.
    assign din_ready    = ~hold_full_r;
    assign serial_out   = out_r;
    assign serial_valid = valid_r;
    assign serial_first = first_r;
    assign serial_last  = last_r;
    assign busy         = busy_r;

    // Next-state, datapath and output decode.
    always_comb begin
        state_nxt_s = state_r;
        sreg_nxt_s  = sreg_r;
        cnt_nxt_s   = cnt_r;
        out_nxt_s   = out_r;
        valid_nxt_s = valid_r;
        first_nxt_s = first_r;
        last_nxt_s  = last_r;
        load_s      = 1'b0;
        accept_s    = din_valid & ~hold_full_r;

        case (state_r)
            IDLE: begin
                if (shift_en && hold_full_r) begin
                    load_s = 1'b1;
                end else if (shift_en) begin
                    out_nxt_s   = 1'b0;
                    valid_nxt_s = 1'b0;
                    first_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (shift_en && (cnt_r < CNT_MAX)) begin
                    out_nxt_s   = first_bit(sreg_r);
                    sreg_nxt_s  = shift_word(sreg_r);
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    first_nxt_s = 1'b0;
                    last_nxt_s  = (cnt_r == CNT_PENULT);
                end else if (shift_en && hold_full_r) begin
                    // Last bit period ends with the next word waiting: gapless reload.
                    load_s = 1'b1;
                end else if (shift_en) begin
                    state_nxt_s = IDLE;
                    out_nxt_s   = 1'b0;
                    valid_nxt_s = 1'b0;
                    first_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                valid_nxt_s = 1'b0;
                out_nxt_s   = 1'b0;
            end
        endcase

        // Loading presents the first bit immediately and parks the rest in sreg.
        if (load_s) begin
            state_nxt_s = SHIFT;
            out_nxt_s   = first_bit(hold_r);
            sreg_nxt_s  = shift_word(hold_r);
            cnt_nxt_s   = CNT_ONE;
            valid_nxt_s = 1'b1;
            first_nxt_s = 1'b1;
            last_nxt_s  = 1'b0;
        end else begin
            cnt_nxt_s = cnt_nxt_s;
        end

        // A new word takes precedence over consumption, so the flag stays set.
        if (accept_s) begin
            hold_nxt_s      = din_data;
            hold_full_nxt_s = 1'b1;
        end else if (load_s) begin
            hold_nxt_s      = hold_r;
            hold_full_nxt_s = 1'b0;
        end else begin
            hold_nxt_s      = hold_r;
            hold_full_nxt_s = hold_full_r;
        end

        busy_nxt_s = (state_nxt_s == SHIFT) | hold_full_nxt_s;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
            sreg_r      <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            out_r       <= 1'b0;
            valid_r     <= 1'b0;
            first_r     <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_r      <= hold_nxt_s;
            hold_full_r <= hold_full_nxt_s;
            sreg_r      <= sreg_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_r       <= out_nxt_s;
            valid_r     <= valid_nxt_s;
            first_r     <= first_nxt_s;
            last_r      <= last_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// -----------------------------------------------------------------------------
// tb_piso_stream
//   Three instances: 8-bit MSB-first (a), 8-bit LSB-first (l), 16-bit MSB-first
//   (c). Expected bits are queued when a word is handed over and compared as the
//   serial stream appears.
// -----------------------------------------------------------------------------
module tb_piso_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  da = 8'h00;  logic va = 1'b0;  logic ra, so_a, sv_a, sf_a, sl_a, bz_a;
    logic [7:0]  dl = 8'h00;  logic vl = 1'b0;  logic rl, so_l, sv_l, sf_l, sl_l, bz_l;
    logic [15:0] dc = 16'h0;  logic vc = 1'b0;  logic rc, so_c, sv_c, sf_c, sl_c, bz_c;
    logic se_a, se_c = 1'b1;
    logic div4 = 1'b0;
    logic [1:0] phase = 2'd0;
    logic stab_chk = 1'b0;

    assign se_a = div4 ? (phase == 2'd0) : 1'b1;

    // Free-running phase for the divide-by-4 tick.
    always @(negedge clk) phase <= phase + 2'd1;

    piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_a (
        .clk(clk), .reset(rst), .din_data(da), .din_valid(va), .din_ready(ra),
        .shift_en(se_a), .serial_out(so_a), .serial_valid(sv_a),
        .serial_first(sf_a), .serial_last(sl_a), .busy(bz_a));

    piso_stream #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(rst), .din_data(dl), .din_valid(vl), .din_ready(rl),
        .shift_en(1'b1), .serial_out(so_l), .serial_valid(sv_l),
        .serial_first(sf_l), .serial_last(sl_l), .busy(bz_l));

    piso_stream #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_c (
        .clk(clk), .reset(rst), .din_data(dc), .din_valid(vc), .din_ready(rc),
        .shift_en(se_c), .serial_out(so_c), .serial_valid(sv_c),
        .serial_first(sf_c), .serial_last(sl_c), .busy(bz_c));

    int n_checks = 0;
    int n_fail   = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboards: entry = {bit, first, last}
    logic [2:0] qa[$];
    logic [2:0] ql[$];
    logic [2:0] qc[$];

    logic tick_a = 1'b0, tick_c = 1'b0;
    logic [3:0] snap_a = 4'h0;
    int run_a = 0, last_run_a = 0;
    int run_l = 0, last_run_l = 0;
    int run_c = 0, last_run_c = 0;

    // Remember whether the edge just taken carried a tick.
    always @(posedge clk) begin
        tick_a <= se_a;
        tick_c <= se_c;
    end

    // Monitor for instance a: scoreboard, off-tick stability, valid run length.
    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst) begin
            if (tick_a && sv_a) begin
                if (qa.size() == 0) check("a_unexpected_bit", 32'd1, 32'd0);
                else begin e = qa.pop_front(); check("a_bit", {so_a, sf_a, sl_a}, e); end
            end
            if (stab_chk && !tick_a) check("a_hold_off_tick", {so_a, sv_a, sf_a, sl_a}, snap_a);
            snap_a <= {so_a, sv_a, sf_a, sl_a};
            if (sv_a) run_a <= run_a + 1;
            else begin
                if (run_a != 0) last_run_a <= run_a;
                run_a <= 0;
            end
        end
    end

    // Monitor for instance l (shift_en tied high).
    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst) begin
            if (sv_l) begin
                if (ql.size() == 0) check("l_unexpected_bit", 32'd1, 32'd0);
                else begin e = ql.pop_front(); check("l_bit", {so_l, sf_l, sl_l}, e); end
                run_l <= run_l + 1;
            end else begin
                if (run_l != 0) last_run_l <= run_l;
                run_l <= 0;
            end
        end
    end

    // Monitor for instance c.
    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst) begin
            if (tick_c && sv_c) begin
                if (qc.size() == 0) check("c_unexpected_bit", 32'd1, 32'd0);
                else begin e = qc.pop_front(); check("c_bit", {so_c, sf_c, sl_c}, e); end
            end
            if (sv_c) run_c <= run_c + 1;
            else begin
                if (run_c != 0) last_run_c <= run_c;
                run_c <= 0;
            end
        end
    end

    function automatic logic ready_of(input int d);
        case (d)
            0:       return ra;
            1:       return rl;
            default: return rc;
        endcase
    endfunction

    function automatic logic busy_of(input int d);
        case (d)
            0:       return bz_a;
            1:       return bz_l;
            default: return bz_c;
        endcase
    endfunction

    function automatic int qsize_of(input int d);
        case (d)
            0:       return qa.size();
            1:       return ql.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic set_in(input int d, input logic [15:0] w, input logic v);
        case (d)
            0:       begin da = w[7:0]; va = v; end
            1:       begin dl = w[7:0]; vl = v; end
            default: begin dc = w;      vc = v; end
        endcase
    endtask

    // Expected serial sequence of one word, built from the shift order.
    task automatic push_exp(input int d, input logic [15:0] w);
        int W;
        logic lsb;
        logic b;
        W   = (d == 2) ? 16 : 8;
        lsb = (d == 1);
        for (int i = 0; i < W; i++) begin
            b = lsb ? w[i] : w[W-1-i];
            case (d)
                0:       qa.push_back({b, i == 0, i == W - 1});
                1:       ql.push_back({b, i == 0, i == W - 1});
                default: qc.push_back({b, i == 0, i == W - 1});
            endcase
        end
    endtask

    // Offer a word (called away from the rising edge); returns one negedge after acceptance.
    task automatic send(input int d, input logic [15:0] w);
        int n;
        n = 0;
        set_in(d, w, 1'b1);
        while (!ready_of(d) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("accept_timeout", 32'd0, 32'd1);
        push_exp(d, w);
        @(negedge clk);
        set_in(d, w, 1'b0);
    endtask

    task automatic wait_idle(input int d, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy_of(d) || qsize_of(d) != 0) && n < 2000);
        if (n >= 2000) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_outs_a", {so_a, sv_a, sf_a, sl_a, bz_a}, 5'b0);
        check("rst_outs_c", {so_c, sv_c, sf_c, sl_c, bz_c}, 5'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {ra, rl, rc}, 3'b111);

        // 1: single word, MSB first.
        send(0, 16'h00A5);
        wait_idle(0, "t1");
        check("t1_run", last_run_a, 8);
        check("t1_idle_outs", {so_a, sv_a, sf_a, sl_a}, 4'b0);

        // 2: back-to-back words with din_valid held high.
        send(0, 16'h00A5);
        send(0, 16'h003C);
        check("t2_ready_low", ra, 1'b0);
        check("t2_busy", bz_a, 1'b1);
        wait_idle(0, "t2");
        check("t2_run", last_run_a, 16);

        // 4: tick every 4th clock; outputs must not move off-tick.
        stab_chk = 1'b1;
        div4 = 1'b1;
        send(0, 16'h00F0);
        wait_idle(0, "t4");
        check("t4_run", last_run_a, 32);
        stab_chk = 1'b0;
        div4 = 1'b0;

        // 5: reset mid-word with a word waiting in hold.
        send(0, 16'h00A5);
        send(0, 16'h003C);
        n = 0;
        while (run_a < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_reached_bit3", run_a, 3);
        check("t5_hold_full", ra, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_rst_outs", {so_a, sv_a, sf_a, sl_a, bz_a}, 5'b0);
        check("t5_rst_ready", ra, 1'b1);
        qa.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(0, 16'h00FF);
        wait_idle(0, "t5");
        check("t5_run", last_run_a, 8);

        // 3: LSB first.
        send(1, 16'h0001);
        wait_idle(1, "t3");
        check("t3_run", last_run_l, 8);
        check("t3_idle_outs", {so_l, sv_l, sf_l, sl_l}, 4'b0);

        // 6: 16-bit word offered while hold is occupied and the tick is stalled.
        se_c = 1'b0;
        send(2, 16'h1234);
        dc = 16'h8001;
        vc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_ready_low", rc, 1'b0);
            check("t6_no_shift", sv_c, 1'b0);
        end
        se_c = 1'b1;
        n = 0;
        while (!rc && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_ready_rise", rc, 1'b1);
        push_exp(2, 16'h8001);
        @(negedge clk);
        vc = 1'b0;
        wait_idle(2, "t6");
        check("t6_run", last_run_c, 32);
        check("t6_idle_outs", {so_c, sv_c, sf_c, sl_c}, 4'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
